// File: rtl/mips_multicycle_core_if.sv
// Control/status bundle of the multi-cycle MIPS core.
// The master side loads imem and starts runs; the core is the slave.
interface mips_multicycle_core_if #(
  parameter int IMEM_AW = 6
);
  logic               start;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic [31:0]        pc;
  logic [31:0]        alu_out;
  logic               retire;
  logic               busy;
  logic               halted;
  logic               illegal;

  modport master (
    output start, imem_we, imem_addr, imem_wdata,
    input  pc, alu_out, retire, busy, halted, illegal
  );

  modport slave (
    input  start, imem_we, imem_addr, imem_wdata,
    output pc, alu_out, retire, busy, halted, illegal
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one ALU,
// with internal imem, dmem and register file.
module mips_multicycle_core #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst_n,
  mips_multicycle_core_if.slave bus
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inc_q, pc_inc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [DMEM_DEPTH];

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        dm_we;
  logic        idle_like;
  logic [31:0] imem_rd;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] rs_val, rt_val;
  logic [31:0] y, alu_res;
  logic        taken;
  logic [31:0] br_tgt, j_tgt;
  logic        is_jr, is_br, is_j, is_jal, is_mem;

  function automatic logic is_legal(
    input logic [5:0] o,
    input logic [5:0] f
  );
    logic ok;
    ok = 1'b0;
    case (o)
      6'h00:
        case (f)
          6'h00, 6'h02, 6'h08,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h2A, 6'h2B: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      6'h02, 6'h03, 6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h23, 6'h2B: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_HALT);
  assign imem_rd = imem[pc_q[2 +: IAW]];

  always_ff @(posedge clk) begin
    if (bus.imem_we && idle_like)
      imem[bus.imem_addr] <= bus.imem_wdata;
  end

  assign op = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign sh = ir_q[10:6];
  assign fn = ir_q[5:0];

  assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  assign is_jr  = (op == 6'h00) && (fn == 6'h08);
  assign is_br  = (op == 6'h04) || (op == 6'h05);
  assign is_j   = (op == 6'h02);
  assign is_jal = (op == 6'h03);
  assign is_mem = (op == 6'h23) || (op == 6'h2B);

  assign y      = (op == 6'h00 || is_br) ? b_q : imm_q;
  assign taken  = (op == 6'h04) ? (a_q == b_q) : (a_q != b_q);
  assign br_tgt = pc_inc_q + {imm_q[29:0], 2'b00};
  assign j_tgt  = {pc_inc_q[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    alu_res = a_q + y;
    if (op == 6'h00) begin
      case (fn)
        6'h22, 6'h23: alu_res = a_q - y;
        6'h24: alu_res = a_q & y;
        6'h25: alu_res = a_q | y;
        6'h2A: alu_res = {31'h0, $signed(a_q) < $signed(y)};
        6'h2B: alu_res = {31'h0, a_q < y};
        6'h00: alu_res = b_q << sh;
        6'h02: alu_res = b_q >> sh;
        6'h08: alu_res = a_q;
        default: alu_res = a_q + y;
      endcase
    end else begin
      case (op)
        6'h0A: alu_res = {31'h0, $signed(a_q) < $signed(y)};
        6'h0B: alu_res = {31'h0, a_q < y};
        6'h0C: alu_res = a_q & y;
        6'h0D: alu_res = a_q | y;
        6'h04, 6'h05: alu_res = a_q - y;
        6'h02, 6'h03: alu_res = pc_inc_q;
        default: alu_res = a_q + y;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_inc_d  = pc_inc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    retire_d  = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = 5'd0;
    rf_wd     = 32'h0;
    dm_we     = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        // Screen the word here so a bad encoding never touches state.
        if (imem_rd[31:26] == 6'h3F) begin
          state_d = S_HALT;
        end else if (!is_legal(imem_rd[31:26], imem_rd[5:0])) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          ir_d     = imem_rd;
          pc_inc_d = pc_q + 32'd4;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (op == 6'h0C || op == 6'h0D)
          imm_d = {16'h0, ir_q[15:0]};
        else
          imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        unique case (1'b1)
          is_jr: begin
            pc_d     = a_q;
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          is_br: begin
            pc_d     = taken ? br_tgt : pc_inc_q;
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          is_j: begin
            pc_d     = j_tgt;
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          is_jal: begin
            pc_d    = j_tgt;
            state_d = S_WB;
          end
          is_mem: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (op == 6'h23) begin
          mdr_d   = dmem_q[alu_q[2 +: DAW]];
          state_d = S_WB;
        end else begin
          dm_we    = 1'b1;
          pc_d     = pc_inc_q;
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (op == 6'h00)
          rf_wa = rd;
        else if (is_jal)
          rf_wa = 5'd31;
        else
          rf_wa = rt;
        rf_wd = (op == 6'h23) ? mdr_q : alu_q;
        if (!is_jal)
          pc_d = pc_inc_q;
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pc_inc_q  <= 32'h0;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      imm_q     <= 32'h0;
      alu_q     <= 32'h0;
      mdr_q     <= 32'h0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_inc_q  <= pc_inc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= 32'h0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++)
        dmem_q[i] <= 32'h0;
    end else if (dm_we) begin
      dmem_q[alu_q[2 +: DAW]] <= b_q;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.alu_out = alu_q;
  assign bus.retire  = retire_q;
  assign bus.busy    = !idle_like;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: expected retire
// results are queued per program and compared on each retire pulse.
module tb_mips_multicycle_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_core_if #(.IMEM_AW(6)) bus();

  mips_multicycle_core #(
    .IMEM_DEPTH(64),
    .DMEM_DEPTH(64),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    bit          chk;
  } exp_t;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] ILL  = 32'hF800_0000;

  exp_t        sb[$];
  int          ret_cyc[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;
  int          ncyc;

  function automatic logic [31:0] ri(
    input logic [5:0] fn, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd,
    input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] ii(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jj(
    input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic push(input logic [31:0] p,
                      input logic [31:0] a,
                      input bit c);
    exp_t e;
    e.pc = p; e.alu = a; e.chk = c;
    sb.push_back(e);
  endtask

  task automatic load_word(input int a, input logic [31:0] w);
    @(negedge clk);
    bus.imem_we = 1'b1;
    bus.imem_addr = a[5:0];
    bus.imem_wdata = w;
    @(negedge clk);
    bus.imem_we = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      @(negedge clk);
      bus.imem_we = 1'b1;
      bus.imem_addr = i[5:0];
      bus.imem_wdata = prog[i];
    end
    @(negedge clk);
    bus.imem_we = 1'b0;
    prog.delete();
  endtask

  task automatic run_prog(input int budget,
                          input bit wr_start,
                          input logic [31:0] wd0,
                          input bit wr_busy,
                          output int nc);
    exp_t e;
    nc = 0;
    ret_cyc.delete();
    @(negedge clk);
    bus.start = 1'b1;
    if (wr_start) begin
      bus.imem_we = 1'b1;
      bus.imem_addr = 6'd0;
      bus.imem_wdata = wd0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.imem_we = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.pc !== 32'h0 ||
        bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL start_state busy=%b pc=%h ill=%b need 1/0/0",
               bus.busy, bus.pc, bus.illegal);
    end
    while (nc < budget) begin
      if (wr_busy && nc == 1) begin
        bus.imem_we = 1'b1;
        bus.imem_addr = 6'd1;
        bus.imem_wdata = ii(6'h08, 5'd0, 5'd15, 16'h0077);
      end
      @(negedge clk);
      bus.imem_we = 1'b0;
      nc++;
      if (bus.retire === 1'b1) begin
        ret_cyc.push_back(nc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_retire pc=%h at cycle %0d",
                   bus.pc, nc);
        end else begin
          e = sb.pop_front();
          if (bus.pc !== e.pc) begin
            errors++;
            $display("FAIL retire_pc got %h need %h", bus.pc, e.pc);
          end
          if (e.chk) begin
            checks++;
            if (bus.alu_out !== e.alu) begin
              errors++;
              $display("FAIL retire_alu got %h need %h (pc %h)",
                       bus.alu_out, e.alu, e.pc);
            end
          end
        end
      end
      if (bus.halted === 1'b1) break;
    end
    checks++;
    if (bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_timeout halted=%b need 1", bus.halted);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_retire left=%0d need 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.imem_we = 1'b0;
    bus.imem_addr = '0;
    bus.imem_wdata = '0;
    rst_n = 1'b0;
    #3;
    checks++;
    if (bus.pc !== 32'h0 || bus.alu_out !== 32'h0 ||
        bus.retire !== 1'b0 || bus.busy !== 1'b0 ||
        bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h alu=%h r%b b%b h%b i%b need 0",
               bus.pc, bus.alu_out, bus.retire, bus.busy,
               bus.halted, bus.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    prog = '{ii(6'h08, 5'd0, 5'd1, 16'd5),
             ii(6'h08, 5'd0, 5'd2, 16'hFFFD),
             ri(6'h20, 5'd1, 5'd2, 5'd3, 5'd0),
             HALT};
    load_prog();
    push(32'h4, 32'h5, 1);
    push(32'h8, 32'hFFFF_FFFD, 1);
    push(32'hC, 32'h2, 1);
    run_prog(200, 0, 32'h0, 0, ncyc);
    checks++;
    if (ncyc != 13 || ret_cyc.size() != 3) begin
      errors++;
      $display("FAIL arith_timing cyc=%0d ret=%0d need 13/3",
               ncyc, ret_cyc.size());
    end
    checks++;
    if (bus.pc !== 32'hC || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL arith_halt pc=%h ill=%b need c/0",
               bus.pc, bus.illegal);
    end
  endtask

  task automatic test_mem();
    prog = '{ii(6'h0D, 5'd0, 5'd1, 16'hDEAD),
             ri(6'h00, 5'd0, 5'd1, 5'd1, 5'd16),
             ii(6'h0D, 5'd1, 5'd1, 16'hBEEF),
             ii(6'h2B, 5'd0, 5'd1, 16'd8),
             ii(6'h23, 5'd0, 5'd4, 16'd8),
             ri(6'h21, 5'd4, 5'd0, 5'd5, 5'd0),
             HALT};
    load_prog();
    push(32'h04, 32'h0000_DEAD, 1);
    push(32'h08, 32'hDEAD_0000, 1);
    push(32'h0C, 32'hDEAD_BEEF, 1);
    push(32'h10, 32'h8, 1);
    push(32'h14, 32'h8, 1);
    push(32'h18, 32'hDEAD_BEEF, 1);
    run_prog(200, 0, 32'h0, 0, ncyc);
    checks++;
    if (ncyc != 26) begin
      errors++;
      $display("FAIL mem_cycles got %0d need 26", ncyc);
    end
    checks++;
    if (ret_cyc.size() != 6 ||
        ret_cyc[3] - ret_cyc[2] != 4 ||
        ret_cyc[4] - ret_cyc[3] != 5) begin
      errors++;
      $display("FAIL mem_cpi sw/lw gaps wrong (need 4 and 5)");
    end
  endtask

  task automatic test_branch();
    prog = '{ii(6'h08, 5'd0, 5'd6, 16'd4),
             ii(6'h08, 5'd6, 5'd6, 16'hFFFF),
             ii(6'h05, 5'd6, 5'd0, 16'hFFFE),
             ii(6'h04, 5'd0, 5'd0, 16'd1),
             ii(6'h08, 5'd0, 5'd7, 16'd99),
             ii(6'h04, 5'd6, 5'd1, 16'd1),
             HALT};
    load_prog();
    push(32'h4, 32'h4, 1);
    for (int k = 3; k >= 0; k--) begin
      push(32'h8, k, 1);
      push(k == 0 ? 32'hC : 32'h4, 32'h0, 0);
    end
    push(32'h14, 32'h0, 0);
    push(32'h18, 32'h0, 0);
    run_prog(300, 0, 32'h0, 0, ncyc);
    checks++;
    if (ncyc != 39 || bus.pc !== 32'h18) begin
      errors++;
      $display("FAIL branch_end cyc=%0d pc=%h need 39/18",
               ncyc, bus.pc);
    end
  endtask

  task automatic test_jump();
    prog = '{jj(6'h03, 26'h8),
             ii(6'h08, 5'd0, 5'd0, 16'd7),
             ri(6'h21, 5'd0, 5'd0, 5'd10, 5'd0),
             jj(6'h02, 26'hC),
             HALT, HALT, HALT, HALT,
             ri(6'h21, 5'd31, 5'd0, 5'd9, 5'd0),
             ri(6'h08, 5'd31, 5'd0, 5'd0, 5'd0),
             HALT, HALT, HALT};
    load_prog();
    push(32'h20, 32'h0, 0);
    push(32'h24, 32'h4, 1);
    push(32'h04, 32'h0, 0);
    push(32'h08, 32'h7, 1);
    push(32'h0C, 32'h0, 1);
    push(32'h30, 32'h0, 0);
    run_prog(200, 0, 32'h0, 0, ncyc);
    checks++;
    if (ncyc != 23 || bus.pc !== 32'h30) begin
      errors++;
      $display("FAIL jump_end cyc=%0d pc=%h need 23/30",
               ncyc, bus.pc);
    end
  endtask

  task automatic illegal_expect();
    push(32'h4, 32'h1, 1);
    push(32'h8, 32'h1, 1);
    push(32'hC, 32'h1, 1);
  endtask

  task automatic test_illegal();
    prog = '{ii(6'h08, 5'd0, 5'd11, 16'd1),
             ri(6'h2B, 5'd0, 5'd11, 5'd12, 5'd0),
             ii(6'h0A, 5'd2, 5'd13, 16'd0),
             ILL};
    load_prog();
    for (int r = 0; r < 3; r++) begin
      if (r == 2)
        load_word(3, ri(6'h01, 5'd1, 5'd2, 5'd3, 5'd0));
      illegal_expect();
      run_prog(200, 0, 32'h0, 0, ncyc);
      checks++;
      if (ncyc != 13 || bus.illegal !== 1'b1 ||
          bus.pc !== 32'hC) begin
        errors++;
        $display("FAIL illegal_%0d cyc=%0d ill=%b pc=%h need 13/1/c",
                 r, ncyc, bus.illegal, bus.pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    load_word(1, HALT);
    push(32'h4, 32'h55, 1);
    run_prog(100, 1, ii(6'h08, 5'd0, 5'd14, 16'h55), 1, ncyc);
    checks++;
    if (ncyc != 5 || bus.pc !== 32'h4 ||
        bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end cyc=%0d pc=%h ill=%b need 5/4/0",
               ncyc, bus.pc, bus.illegal);
    end
  endtask

  task automatic test_reset_mid();
    prog = '{ii(6'h08, 5'd0, 5'd16, 16'd3),
             ii(6'h23, 5'd0, 5'd17, 16'd8),
             ri(6'h21, 5'd17, 5'd16, 5'd18, 5'd0),
             HALT};
    load_prog();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.alu_out !== 32'h8) begin
      errors++;
      $display("FAIL pre_reset busy=%b alu=%h need 1/8",
               bus.busy, bus.alu_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.alu_out !== 32'h0 ||
        bus.busy !== 1'b0 || bus.retire !== 1'b0 ||
        bus.halted !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset pc=%h alu=%h busy=%b need 0/0/0",
               bus.pc, bus.alu_out, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h4, 32'h3, 1);
    push(32'h8, 32'h8, 1);
    push(32'hC, 32'h3, 1);
    run_prog(200, 0, 32'h0, 0, ncyc);
    checks++;
    if (ncyc != 14) begin
      errors++;
      $display("FAIL rerun_cycles got %0d need 14", ncyc);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem();
    test_branch();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
